// File: rtl/mod4_seq_gen_pkg.sv
// Shared definitions for the mod-4 residue sequence generator.
package mod4_seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned STEP = 4;

endpackage

// File: rtl/mod4_seq_gen.sv
// Streams every (W+1)-bit value with v % 4 == RESIDUE, ascending, over a valid/ready
// handshake; pulses done_o after the final transfer of an uninterrupted burst.
module mod4_seq_gen
  import mod4_seq_gen_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned RESIDUE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         halt,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W:0]   data_o,
  output logic         last_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] cnt_o
);

  localparam int unsigned DW   = W + 1;
  localparam logic [W:0]  MAXV = DW'((1 << DW) - STEP + RESIDUE);

  if (RESIDUE > 3) begin : g_bad_residue
    $error("mod4_seq_gen: RESIDUE must be in 0..3");
  end

  state_t       r_state;
  logic [W:0]   r_data;
  logic [W-1:0] r_cnt;
  logic         r_valid;
  logic         r_last;
  logic         r_busy;
  logic         r_done;

  logic         w_xfer;
  logic         w_at_max;
  logic [W:0]   w_data_inc;

  assign w_xfer     = r_valid & ready_i;
  assign w_at_max   = (r_data == MAXV);
  assign w_data_inc = r_data + DW'(STEP);

  // FSM, value register and transfer counter; every output comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= DW'(RESIDUE);
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_data  <= DW'(RESIDUE);
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= (DW'(RESIDUE) == MAXV);
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + W'(1);
          end
          // halt wins over completion, so an aborted final transfer yields no done_o.
          if (halt) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_xfer) begin
            if (w_at_max) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_data <= w_data_inc;
              r_last <= (w_data_inc == MAXV);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign last_o  = r_last;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign cnt_o   = r_cnt;

endmodule

// File: tb/tb_mod4_seq_gen.sv
// Bench for mod4_seq_gen: RESIDUE=1 and RESIDUE=3 instances share stimulus and are
// compared cycle by cycle against a burst-position reference model.
module tb_mod4_seq_gen;

  localparam int unsigned W = 4;
  localparam int          N = 1 << (W - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic ready_i = 1'b0;

  logic         v1, l1, b1, d1;
  logic [W:0]   dat1;
  logic [W-1:0] c1;
  logic         v3, l3, b3, d3;
  logic [W:0]   dat3;
  logic [W-1:0] c3;

  always #5 clk = ~clk;

  mod4_seq_gen #(.W(W), .RESIDUE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .ready_i(ready_i),
    .valid_o(v1), .data_o(dat1), .last_o(l1), .busy_o(b1), .done_o(d1), .cnt_o(c1)
  );

  mod4_seq_gen #(.W(W), .RESIDUE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .ready_i(ready_i),
    .valid_o(v3), .data_o(dat3), .last_o(l3), .busy_o(b3), .done_o(d3), .cnt_o(c3)
  );

  int total = 0;
  int bad = 0;
  int dpulses = 0;

  // Reference model: burst active flag, position in the burst, transfers, done pulse.
  int res[2] = '{1, 3};
  int m_act[2];
  int m_idx[2];
  int m_cnt[2];
  int m_done[2];

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input int k, input logic v, input logic b, input logic l,
                            input logic d, input logic [W:0] dat, input logic [W-1:0] cnt);
    string p;
    p = (k == 0) ? "r1" : "r3";
    check_eq({p, ".valid"}, int'(v), m_act[k]);
    check_eq({p, ".busy"},  int'(b), m_act[k]);
    check_eq({p, ".last"},  int'(l), int'(m_act[k] != 0 && m_idx[k] == N - 1));
    check_eq({p, ".done"},  int'(d), m_done[k]);
    check_eq({p, ".cnt"},   int'(cnt), m_cnt[k]);
    if (m_act[k] != 0) check_eq({p, ".data"}, int'(dat), res[k] + 4 * m_idx[k]);
    if (k == 0 && d) dpulses++;
  endtask

  task automatic check_reset_vals();
    check_eq("rst.r1.valid", int'(v1), 0);
    check_eq("rst.r1.busy",  int'(b1), 0);
    check_eq("rst.r1.last",  int'(l1), 0);
    check_eq("rst.r1.done",  int'(d1), 0);
    check_eq("rst.r1.data",  int'(dat1), 1);
    check_eq("rst.r1.cnt",   int'(c1), 0);
    check_eq("rst.r3.valid", int'(v3), 0);
    check_eq("rst.r3.data",  int'(dat3), 3);
    check_eq("rst.r3.cnt",   int'(c3), 0);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_idx[k] = 0; m_cnt[k] = 0; m_done[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k);
    if (m_done[k] != 0) begin
      m_done[k] = 0;
    end else if (m_act[k] != 0) begin
      if (ready_i) m_cnt[k]++;
      if (halt) begin
        m_act[k] = 0;
      end else if (ready_i) begin
        if (m_idx[k] == N - 1) begin
          m_act[k] = 0;
          m_done[k] = 1;
        end else begin
          m_idx[k]++;
        end
      end
    end else if (start) begin
      m_act[k] = 1; m_idx[k] = 0; m_cnt[k] = 0;
    end
  endfunction

  // Called at a falling edge: check current outputs, apply inputs, advance model one edge.
  task automatic cycle(input logic s, input logic h, input logic r);
    check_outs(0, v1, b1, l1, d1, dat1, c1);
    check_outs(1, v3, b3, l3, d3, dat3, c3);
    start = s; halt = h; ready_i = r;
    if (v1 && ready_i) check_eq("mon.r1", int'(dat1) % 4, 1);
    if (v3 && ready_i) check_eq("mon.r3", int'(dat3) % 4, 3);
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_idle(input int mode);
    for (int i = 0; i < 40 && (m_act[0] != 0 || m_done[0] != 0); i++)
      cycle(1'b0, 1'b0, (mode == 0) ? 1'b1 : ((i % 3) == 0));
    check_eq("idle_bound", m_act[0] + m_done[0], 0);
  endtask

  task automatic run_to_idx(input int target);
    for (int i = 0; i < 40 && m_idx[0] < target; i++) cycle(1'b0, 1'b0, 1'b1);
    check_eq("idx_bound", m_idx[0], target);
  endtask

  task automatic async_reset();
    start = 1'b0; halt = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);

    // Full burst with ready held high.
    dpulses = 0;
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idle(0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("burst.done_pulses", dpulses, 1);
    check_eq("burst.r1.cnt", int'(c1), 8);
    check_eq("burst.r3.cnt", int'(c3), 8);
    check_eq("burst.r1.final", int'(dat1), 29);
    check_eq("burst.r3.final", int'(dat3), 31);

    // Back-pressure pattern 1,0,0,1,...
    dpulses = 0;
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idle(1);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("bp.done_pulses", dpulses, 1);
    check_eq("bp.r1.cnt", int'(c1), 8);

    // Halt on the third transfer.
    dpulses = 0;
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idx(2);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    check_eq("halt.r1.cnt", int'(c1), 3);
    check_eq("halt.done_pulses", dpulses, 0);

    // Halt together with the final transfer: halt wins.
    dpulses = 0;
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idx(N - 1);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check_eq("haltmax.r1.cnt", int'(c1), 8);
    check_eq("haltmax.done_pulses", dpulses, 0);

    // start re-pulsed mid-burst is ignored.
    dpulses = 0;
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idx(3);
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idle(0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("restart.done_pulses", dpulses, 1);
    check_eq("restart.r1.cnt", int'(c1), 8);

    // Asynchronous reset mid-burst, then a fresh burst.
    dpulses = 0;
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idx(4);
    async_reset();
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idle(0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("arst.done_pulses", dpulses, 1);
    check_eq("arst.r1.cnt", int'(c1), 8);

    // Randomized start/halt/ready traffic.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
